// File: rtl/l2_mem_bus_ctrl.sv
// rtl/l2_mem_bus_ctrl.sv - L2 fill / write-back arbiter and burst sequencer for the main-memory port
//
// Optional watchdog: define MEM_TIMEOUT_EN to abort a stalled burst after TIMEOUT
// strobe-less XFER cycles; without it the burst waits forever and err stays 0.
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   rd_req, rd_addr            line-fill request, held until rd_done
//   rd_gnt, rd_vld, rd_beat    fill owns the bus / mem_rdata valid / beat index
//   rd_done                    one-cycle fill completion
//   wb_req, wb_addr, wb_data   write-back request, held until wb_done; current beat data
//   wb_pop, wb_gnt, wb_done    beat consumed / write-back owns the bus / completion
//   mem_addrstb, mem_we        one-cycle address strobe, 1 = write
//   mem_addr, mem_wdata        line-aligned address, write data
//   mem_rdata, mem_stb         read data (consumed by the L2 directly), per-beat strobe
//   busy, err                  transaction in flight, one-cycle watchdog abort
module l2_mem_bus_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int BEATS      = 4,
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_gnt,
    output logic                     rd_vld,
    output logic [$clog2(BEATS)-1:0] rd_beat,
    output logic                     rd_done,
    input  logic                     wb_req,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     wb_pop,
    output logic                     wb_gnt,
    output logic                     wb_done,
    output logic                     mem_addrstb,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_stb,
    output logic                     busy,
    output logic                     err
);

    localparam int BEAT_W   = $clog2(BEATS);
    localparam int OFF_W    = $clog2(BEATS * DATA_W / 8);
    localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int WD_W     = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0]   ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);

`ifdef MEM_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                dir_wr_q, dir_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                wb_wins;

    // Fill data goes straight from memory to the L2; only rd_vld/rd_beat qualify it here.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    // Reads have priority unless the write-back has already been passed over STARVE_MAX times.
    assign wb_wins = wb_req && (!rd_req || (starve_q == STARVE_LIM));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_wr_q <= 1'b0;
            addr_q   <= '0;
            beat_q   <= '0;
            starve_q <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            dir_wr_q <= dir_wr_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_wr_d    = dir_wr_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        starve_d    = starve_q;
        wd_d        = wd_q;
        rd_gnt      = 1'b0;
        rd_vld      = 1'b0;
        rd_beat     = '0;
        rd_done     = 1'b0;
        wb_pop      = 1'b0;
        wb_gnt      = 1'b0;
        wb_done     = 1'b0;
        mem_addrstb = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        busy        = 1'b0;
        err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wb_wins) begin
                    dir_wr_d = 1'b1;
                    addr_d   = wb_addr & ALIGN_MASK;
                    starve_d = '0;
                    state_d  = S_ADDR;
                end else if (rd_req) begin
                    dir_wr_d = 1'b0;
                    addr_d   = rd_addr & ALIGN_MASK;
                    if (wb_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                    state_d = S_ADDR;
                end
            end

            S_ADDR: begin
                busy        = 1'b1;
                rd_gnt      = !dir_wr_q;
                wb_gnt      = dir_wr_q;
                mem_addrstb = 1'b1;
                mem_addr    = addr_q;
                mem_we      = dir_wr_q;
                state_d     = S_XFER;
            end

            S_XFER: begin
                busy     = 1'b1;
                rd_gnt   = !dir_wr_q;
                wb_gnt   = dir_wr_q;
                mem_addr = addr_q;
                mem_we   = dir_wr_q;
                if (dir_wr_q) begin
                    mem_wdata = wb_data;
                end else begin
                    rd_beat = beat_q;
                end

                if (mem_stb) begin
                    rd_vld = !dir_wr_q;
                    wb_pop = dir_wr_q;
                    wd_d   = '0;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (WD_EN) begin
                    // Abort on the TIMEOUT-th consecutive strobe-less cycle, no done pulse.
                    if (wd_q == WD_LAST) begin
                        err     = 1'b1;
                        beat_d  = '0;
                        wd_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                rd_gnt  = !dir_wr_q;
                wb_gnt  = dir_wr_q;
                rd_done = !dir_wr_q;
                wb_done = dir_wr_q;
                beat_d  = '0;
                wd_d    = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_mem_bus_ctrl.sv
// tb/tb_l2_mem_bus_ctrl.sv - self-checking bench for l2_mem_bus_ctrl
module tb_l2_mem_bus_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int BEATS  = 4;

    logic              clk;
    logic              rst_n;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_vld;
    logic [1:0]        rd_beat;
    logic              rd_done;
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_pop;
    logic              wb_gnt;
    logic              wb_done;
    logic              mem_addrstb;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stb;
    logic              busy;
    logic              err;

    l2_mem_bus_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .STARVE_MAX(2), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld),
        .rd_beat(rd_beat), .rd_done(rd_done),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pop(wb_pop),
        .wb_gnt(wb_gnt), .wb_done(wb_done),
        .mem_addrstb(mem_addrstb), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stb(mem_stb),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
    } sb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        int          gap;
        logic [31:0] exp_addr;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[5];

    int total = 0;
    int bad   = 0;

    int rd_issue = 0, rd_served = 0, wb_issue = 0, wb_served = 0;
    int rd_done_cnt = 0, wb_done_cnt = 0, err_cnt = 0, rd_vld_cnt = 0;
    int exp_rd = 0, exp_wb = 0, exp_err = 0;
    int mon_beat = 0;
    logic cur_we = 1'b0;

    bit mem_auto = 1'b0;
    int mem_gap  = 0;
    logic man_stb = 1'b0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] wpat(int k);
        return {32'hC0DE_0000 + 32'(k), 32'h1234_5678 ^ 32'(k)};
    endfunction

    // Requester: holds each request until its done (or a fill abort) is observed.
    initial begin
        logic rdd, wbd, pop, e, rg;
        int   wb_k;
        wb_k    = 0;
        rd_req  = 1'b0;
        wb_req  = 1'b0;
        wb_data = wpat(0);
        forever begin
            @(negedge clk);
            rdd = rd_done; wbd = wb_done; pop = wb_pop; e = err; rg = rd_gnt;
            @(posedge clk);
            #2;
            if (rdd) rd_served++;
            if (wbd) begin wb_served++; wb_k = 0; end
            if (pop) wb_k++;
            if (e) begin wb_k = 0; if (rg) rd_served++; end
            if (!rst_n) wb_k = 0;
            rd_req  = (rd_issue != rd_served);
            wb_req  = (wb_issue != wb_served);
            wb_data = wpat(wb_k);
        end
    end

    // Memory: in auto mode answers each addrstb with BEATS strobes spaced by mem_gap idle cycles.
    initial begin
        mem_stb   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_auto) begin
                mem_stb = man_stb;
            end else if (mem_addrstb) begin
                for (int b = 0; b < BEATS; b++) begin
                    repeat (mem_gap) begin
                        @(posedge clk); #2;
                        mem_stb = 1'b0;
                    end
                    @(posedge clk); #2;
                    mem_stb   = 1'b1;
                    mem_rdata = {2{32'(b)}};
                end
                @(posedge clk); #2;
                mem_stb = 1'b0;
            end else begin
                mem_stb = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_beat = 0;
        end else begin
            if (mem_addrstb) begin
                if (sb.size() == 0) begin
                    chk("spurious_addrstb", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("addrstb_we_addr", {mem_we, mem_addr}, {e.we, e.addr});
                    chk("addrstb_gnt", {rd_gnt, wb_gnt}, {~e.we, e.we});
                end
                cur_we = mem_we;
            end
            if (rd_vld) begin
                chk("rd_beat", rd_beat, mon_beat);
                mon_beat++;
                rd_vld_cnt++;
            end
            if (wb_pop) begin
                chk("wb_wdata", mem_wdata, wpat(mon_beat));
                mon_beat++;
            end
            if (rd_done || wb_done) begin
                chk("done_beats", mon_beat, BEATS);
                chk("done_dir", {wb_done, rd_done}, {cur_we, ~cur_we});
                mon_beat = 0;
                if (rd_done) rd_done_cnt++;
                else wb_done_cnt++;
            end
            if (err) begin
                err_cnt++;
                mon_beat = 0;
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy && !rd_req && !wb_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_wait_expired", 0, 1);
    endtask

    initial begin
        int got_stb, got_done, vld0, done0, n;
        bit found;

        vecs[0] = '{1'b0, 32'h0000_1234, 0, 32'h0000_1220};
        vecs[1] = '{1'b1, 32'h0000_8040, 2, 32'h0000_8040};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFE0};
        vecs[3] = '{1'b1, 32'h1234_567F, 0, 32'h1234_5660};
        vecs[4] = '{1'b0, 32'h0000_001F, 3, 32'h0000_0000};

        rst_n   = 1'b0;
        rd_addr = '0;
        wb_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {rd_gnt, rd_vld, rd_beat, rd_done, wb_pop, wb_gnt, wb_done, mem_addrstb,
             mem_we, mem_addr, mem_wdata, busy, err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven single transactions.
        mem_auto = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(posedge clk);
            #1;
            mem_gap = vecs[i].gap;
            sb.push_back('{we: vecs[i].we, addr: vecs[i].exp_addr});
            if (vecs[i].we) begin
                wb_addr = vecs[i].addr; wb_issue++; exp_wb++;
            end else begin
                rd_addr = vecs[i].addr; rd_issue++; exp_rd++;
            end
            got_stb  = -1;
            got_done = -1;
            for (int c = 1; c <= 200; c++) begin
                @(negedge clk);
                if (mem_addrstb && got_stb < 0) got_stb = c;
                if (rd_done || wb_done) begin
                    got_done = c;
                    break;
                end
            end
            chk("addrstb_latency", got_stb, 2);
            chk("done_latency", got_done, 3 + BEATS * (vecs[i].gap + 1));
            wait_idle(50);
        end

        // Contention: both held, expect rd, rd, wb, rd, rd, wb.
        repeat (2) @(posedge clk);
        #1;
        mem_gap = 0;
        rd_addr = 32'h0000_2000;
        wb_addr = 32'h0000_3000;
        sb.push_back('{1'b0, 32'h0000_2000});
        sb.push_back('{1'b0, 32'h0000_2000});
        sb.push_back('{1'b1, 32'h0000_3000});
        sb.push_back('{1'b0, 32'h0000_2000});
        sb.push_back('{1'b0, 32'h0000_2000});
        sb.push_back('{1'b1, 32'h0000_3000});
        rd_issue += 4; wb_issue += 2; exp_rd += 4; exp_wb += 2;
        wait_idle(600);
        chk("grant_order_consumed", sb.size(), 0);

        // Reset after two read beats, then the held fill must be re-issued.
        repeat (2) @(posedge clk);
        #1;
        mem_auto = 1'b0;
        man_stb  = 1'b0;
        rd_addr  = 32'h0000_0ABC;
        sb.push_back('{1'b0, 32'h0000_0AA0});
        rd_issue++; exp_rd++;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_addrstb) begin found = 1'b1; break; end
        end
        chk("reset_test_addrstb_seen", found, 1);
        done0 = rd_done_cnt;
        @(posedge clk); #1; man_stb = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; man_stb = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midburst_reset_outputs",
            {rd_gnt, rd_vld, rd_beat, rd_done, wb_pop, wb_gnt, wb_done, mem_addrstb,
             mem_we, mem_addr, mem_wdata, busy, err}, 0);
        mem_auto = 1'b1;
        mem_gap  = 0;
        sb.push_back('{1'b0, 32'h0000_0AA0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_idle(100);
        chk("reset_reissue_done_count", rd_done_cnt - done0, 1);

        // Stray strobes in IDLE and ADDR must not count as beats.
        repeat (2) @(posedge clk);
        #1;
        mem_auto = 1'b0;
        man_stb  = 1'b1;
        vld0     = rd_vld_cnt;
        done0    = rd_done_cnt;
        rd_addr  = 32'h0000_0040;
        @(posedge clk); #1;
        sb.push_back('{1'b0, 32'h0000_0040});
        rd_issue++; exp_rd++;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        @(posedge clk); #1; man_stb = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy_after_3", busy, 1);
        chk("stray_vld_after_3", rd_vld_cnt - vld0, 3);
        chk("stray_no_done_after_3", rd_done_cnt - done0, 0);
        @(posedge clk); #1; man_stb = 1'b1;
        @(posedge clk); #1; man_stb = 1'b0;
        @(negedge clk);
        chk("stray_done_after_4th", rd_done, 1);
        wait_idle(50);

`ifdef MEM_TIMEOUT_EN
        // One beat, then stall until the watchdog fires.
        repeat (2) @(posedge clk);
        #1;
        done0   = rd_done_cnt;
        rd_addr = 32'h0000_0500;
        sb.push_back('{1'b0, 32'h0000_0500});
        rd_issue++; exp_err++;
        @(posedge clk); #1;
        @(posedge clk); #1; man_stb = 1'b1;
        @(posedge clk); #1; man_stb = 1'b0;
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (err) begin n = c; break; end
        end
        chk("timeout_err_cycles", n, 10);
        @(negedge clk);
        chk("timeout_busy_after", busy, 0);
        wait_idle(50);
        chk("timeout_no_done", rd_done_cnt - done0, 0);
`endif

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("rd_done_total", rd_done_cnt, exp_rd);
        chk("wb_done_total", wb_done_cnt, exp_wb);
        chk("err_total", err_cnt, exp_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
